regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the RV32I core and its variants: one write port, NUM_RD registered read ports, write-to-read bypass, an optional hardwired-zero entry, and a stall-safe read hold. An internal clear sequencer zeroes every entry after reset or on request, one entry per cycle. No reset is needed on the storage array, so it still maps to iCE40 block RAM or distributed RAM. It sits between decode (read addresses) and writeback (write port) and replaces the fixed 2-port, 32×32 file.

## Interface
- DATA_W, 32: entry width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 = entry 0 is never written and always reads 0.
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clear_req  in  1  one-cycle pulse; starts a full clear. Honoured only in IDLE.
- ready  out  1  1 = file usable; 0 while clearing.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  1 = capture new read addresses; 0 = stall (hold addresses).
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port p at [p*DATA_W +: DATA_W].

## Operation
- FSM states: CLEAR and IDLE.
  - Reset: state=CLEAR, clr_idx=0, ready=0, all rd_data=0, all address latches=0.
  - CLEAR: each cycle writes 0 to entry clr_idx, then clr_idx+1. At clr_idx=DEPTH-1: write 0, go to IDLE, clr_idx wraps to 0.
  - IDLE: ready=1. clear_req=1 goes to CLEAR with clr_idx=0; ready drops the next cycle.
  - clear_req during CLEAR is ignored; the clear does not restart.
- Effective write: we_eff = wr_en & (state==IDLE) & !(ZERO_REG && wr_addr==0). Writes during CLEAR are dropped, not queued.
- Read address latch, per port:
  - rd_en=1: raddr_q[p] <= rd_addr[p].
  - rd_en=0: raddr_q[p] holds.
  - The latch updates in every state.
- Read data register, per port, evaluated each posedge using the next address a (new rd_addr[p] if rd_en, else raddr_q[p]):
  - State CLEAR, or (ZERO_REG and a==0): 0.
  - Else if we_eff and wr_addr==a: wr_data (bypass).
  - Else: mem[a].
- Consequence of the read rule: a stalled port tracks writes to its held address. The output never goes stale during a stall.
- No read/write ordering hazards beyond the bypass above. All ports are independent and may use the same address.

## Timing
- Write: mem updated at the posedge where we_eff=1. It is visible through the array on reads evaluated at the following posedge, and through the bypass at the same posedge.
- Read latency: 1 cycle. rd_data valid after the posedge that sampled the address.
- Simultaneous write and read of the same nonzero address: next cycle's rd_data = new wr_data, on every matching port.
- Clear duration: ready rises exactly DEPTH cycles after the first posedge with rst_n high (32 cycles at default). The same DEPTH cycles apply after the cycle that accepts clear_req.
- rd_data is 0 on every port in the cycle after any posedge in CLEAR. The first nonzero data can appear on the posedge after ready=1.
- Reset asserted mid-clear or mid-operation: outputs go to reset values immediately, asynchronously. The array is not reset; the clear sequence repeats.

## Structure
- Shared package regfile_pkg holds:
  - State encoding: ST_CLEAR=1'b0, ST_IDLE=1'b1.
  - Default width constants: RV32 DATA_W=32, ADDR_W=5.
- Sub-module regfile_rd_port: one address latch, bypass compare and output register. Generated NUM_RD times.
- The top level holds the array, the FSM and clr_idx.

## Test plan
- Reset release: hold rd_addr=3 with rd_en=1. Required: ready=0 for 32 cycles then 1; rd_data=0 throughout.
- Write then read: write x5=0xDEADBEEF, then read port0=5, port1=5 next cycle. Required: both ports show 0xDEADBEEF one cycle after the address.
- Bypass: in one cycle write x7=0x12345678 and read port1=7 (mem held 0xAAAA0000). Required: next-cycle rd_data port1 = 0x12345678.
- Zero register: write x0=0xFFFFFFFF and read x0 the same cycle and the next cycle. Required: 0 both times.
- Stall: with rd_en=0 holding address 9, write x9=0x55, then x9=0x66 on consecutive cycles. Required: port output shows 0x55 then 0x66.
- Clear request: fill x1..x31 with nonzero values, pulse clear_req, and write x4 during the clear. Required:
  - ready=0 for 32 cycles; the write is dropped.
  - After ready=1, every entry reads 0.
  - A repeat of this scenario with rst_n pulsed low mid-clear gives the same end result.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  // Two-state sequencer. The encoding is fixed so that ready can be read
  // straight off the state bit.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Default RV32 geometry: 32 entries of 32 bits.
  localparam int RV32_DATA_W = 32;
  localparam int RV32_ADDR_W = 5;

  // Supported range of read ports.
  localparam int MIN_NUM_RD = 1;
  localparam int MAX_NUM_RD = 4;

  // True when an address hits the hardwired-zero entry.
  function automatic logic is_zero_hit(input logic zero_reg_en, input logic addr_is_zero);
    return zero_reg_en & addr_is_zero;
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// One registered read port: address latch with stall hold, write-to-read
// bypass and the output data register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RV32_DATA_W,
  parameter int ADDR_W   = RV32_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_clearing,
  input  logic              i_we_eff,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [ADDR_W-1:0] o_next_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [ADDR_W-1:0] r_raddr;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] w_rd_data_nxt;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_zero_hit;

  // The address used this edge: a fresh one when enabled, else the held one.
  // Because a stalled port keeps evaluating its held address, it keeps
  // tracking writes to that entry instead of going stale.
  assign w_next_addr = i_rd_en ? i_rd_addr : r_raddr;
  assign o_next_addr = w_next_addr;
  assign w_zero_hit  = is_zero_hit(ZERO_REG, (w_next_addr == '0));

  // Select next output: forced zero, bypassed write data, or array contents.
  always_comb begin
    // NOTE: assign the default first so every path drives the signal and no latch is inferred.
    w_rd_data_nxt = i_mem_rdata;
    if (i_clearing || w_zero_hit) begin
      w_rd_data_nxt = '0;
    end else if (i_we_eff && (i_wr_addr == w_next_addr)) begin
      w_rd_data_nxt = i_wr_data;
    end
  end

  // Address latch and output register; both reset so outputs are defined
  // immediately on reset assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr   <= '0;
      r_rd_data <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops see pre-edge values.
      r_raddr   <= w_next_addr;
      r_rd_data <= w_rd_data_nxt;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one write port, NUM_RD registered read
// ports with bypass, optional hardwired-zero entry, and a clear sequencer
// that zeroes one entry per cycle after reset or on request.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RV32_DATA_W,
  parameter int ADDR_W   = RV32_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;
  logic              w_clearing;
  logic              w_we_eff;

  // Single physical write port shared by the sequencer and the user write.
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_next_addr  [NUM_RD];
  logic [DATA_W-1:0] w_port_rdata [NUM_RD];

  assign w_clearing = (r_state == ST_CLEAR);
  assign ready      = (r_state == ST_IDLE);

  // User writes count only when idle and never to the hardwired-zero entry;
  // writes arriving during a clear are dropped.
  assign w_we_eff = wr_en && (r_state == ST_IDLE)
                 && !is_zero_hit(ZERO_REG, (wr_addr == '0));

  // State and clear index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next-state logic: walk every entry in CLEAR, accept clear_req in IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        // clear_req is deliberately ignored here so a clear never restarts.
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt   = ST_IDLE;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_idx_nxt = '0;
      end
    endcase
  end

  // Write-port mux: the sequencer owns the port while clearing.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = wr_addr;
    w_mem_wdata = wr_data;
    if (w_clearing) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_clr_idx;
      w_mem_wdata = '0;
    end else if (w_we_eff) begin
      w_mem_we    = 1'b1;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: the array is intentionally not reset so it can map onto block or
    // distributed RAM; the clear sequencer provides the zeroed contents.
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // One read port per requested lane; each gets its own array read at the
  // address it is about to register.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign w_port_rdata[p] = r_mem[w_next_addr[p]];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rd_en     (rd_en),
      .i_rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
      .i_clearing  (w_clearing),
      .i_we_eff    (w_we_eff),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .o_next_addr (w_next_addr[p]),
      .i_mem_rdata (w_port_rdata[p]),
      .o_rd_data   (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes hand-computed expected
// values tagged with the cycle they must appear; a monitor pops and compares.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic               clk;
  logic               rst_n;
  logic               clear_req;
  logic               ready;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               rd_en;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;

  typedef enum int { K_READY, K_RD0, K_RD1 } kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .ready     (ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record one check result and report failures.
  task automatic check(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok)
      n_pass++;
    else
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
  endtask

  // Expect value v on output k after the next rising edge.
  task automatic exp_next(input kind_e k, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + 1;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic set_wr(input logic en, input int a, input logic [31:0] d);
    wr_en   = en;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  task automatic set_rd(input logic en, input int a0, input int a1);
    rd_en   = en;
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: at each falling edge compare every entry due this cycle.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        case (e.kind)
          K_READY: act = {31'd0, ready};
          K_RD0:   act = rd_data[0*DW +: DW];
          default: act = rd_data[1*DW +: DW];
        endcase
        check((e.cyc == cyc) && (act === e.val), e.name, act, e.val);
      end
    end
  end

  // Write x1..x31 with i*0x01010101, checking bypass on port0 and the
  // previous entry through the array on port1.
  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      set_wr(1'b1, i, 32'h0101_0101 * i);
      set_rd(1'b1, i, i - 1);
      exp_next(K_RD0, 32'h0101_0101 * i, "fill_bypass");
      exp_next(K_RD1, 32'h0101_0101 * (i - 1), "fill_prev");
      tick();
    end
    set_wr(1'b0, 0, 32'h0);
  endtask

  // n cycles inside a clear: a dropped write to x4 and an ignored clear_req.
  task automatic clear_cycles(input int n, input bit last_ready);
    for (int k = 1; k <= n; k++) begin
      set_wr(k == 10, 4, 32'hBAD0_BAD0);
      clear_req = (k == 20);
      exp_next(K_READY, {31'd0, last_ready && (k == n)}, "clr_ready");
      exp_next(K_RD0, 32'h0, "clr_rd0");
      exp_next(K_RD1, 32'h0, "clr_rd1");
      tick();
    end
    clear_req = 1'b0;
    set_wr(1'b0, 0, 32'h0);
  endtask

  task automatic verify_zero();
    for (int i = 0; i < 32; i += 2) begin
      set_rd(1'b1, i, i + 1);
      exp_next(K_READY, 32'd1, "vz_ready");
      exp_next(K_RD0, 32'h0, "vz_rd0");
      exp_next(K_RD1, 32'h0, "vz_rd1");
      tick();
    end
  endtask

  task automatic clear_scenario(input bit mid_reset);
    fill();
    set_rd(1'b1, 4, 31);
    exp_next(K_RD0, 32'h0404_0404, "prefill_x4");
    exp_next(K_RD1, 32'h1F1F_1F1F, "prefill_x31");
    tick();
    clear_req = 1'b1;
    exp_next(K_READY, 32'd0, "clr_accept_ready");
    exp_next(K_RD0, 32'h0404_0404, "clr_accept_rd0");
    exp_next(K_RD1, 32'h1F1F_1F1F, "clr_accept_rd1");
    tick();
    clear_req = 1'b0;
    if (mid_reset) begin
      clear_cycles(12, 1'b0);
      rst_n = 1'b0;
      for (int j = 0; j < 2; j++) begin
        exp_next(K_READY, 32'd0, "rst_ready");
        exp_next(K_RD0, 32'h0, "rst_rd0");
        exp_next(K_RD1, 32'h0, "rst_rd1");
        tick();
      end
      rst_n = 1'b1;
    end
    clear_cycles(32, 1'b1);
    verify_zero();
  endtask

  initial begin : stimulus
    rst_n     = 1'b0;
    clear_req = 1'b0;
    set_wr(1'b0, 0, 32'h0);
    set_rd(1'b1, 3, 3);
    tick();
    exp_next(K_READY, 32'd0, "in_reset_ready");
    exp_next(K_RD0, 32'h0, "in_reset_rd0");
    tick();

    // Reset release: ready low for 32 cycles, data zero throughout.
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      exp_next(K_READY, {31'd0, k >= 32}, "rel_ready");
      exp_next(K_RD0, 32'h0, "rel_rd0");
      exp_next(K_RD1, 32'h0, "rel_rd1");
      tick();
    end
    check(ready === 1'b1, "rel_done_ready", {31'd0, ready}, 32'd1);
    check(rd_data === '0, "rel_done_rd", rd_data[31:0], 32'h0);

    // Write then read on both ports.
    set_wr(1'b1, 5, 32'hDEAD_BEEF);
    set_rd(1'b1, 0, 0);
    exp_next(K_RD0, 32'h0, "wr5_rd_x0");
    tick();
    set_wr(1'b0, 0, 32'h0);
    set_rd(1'b1, 5, 5);
    exp_next(K_RD0, 32'hDEAD_BEEF, "rd5_p0");
    exp_next(K_RD1, 32'hDEAD_BEEF, "rd5_p1");
    tick();

    // Bypass: x7 holds 0xAAAA0000, overwritten while being read.
    set_wr(1'b1, 7, 32'hAAAA_0000);
    tick();
    set_wr(1'b1, 7, 32'h1234_5678);
    set_rd(1'b1, 5, 7);
    exp_next(K_RD0, 32'hDEAD_BEEF, "byp_p0");
    exp_next(K_RD1, 32'h1234_5678, "byp_p1");
    tick();
    set_wr(1'b0, 0, 32'h0);
    exp_next(K_RD1, 32'h1234_5678, "byp_array");
    tick();

    // Zero register ignores writes.
    set_wr(1'b1, 0, 32'hFFFF_FFFF);
    set_rd(1'b1, 0, 0);
    exp_next(K_RD0, 32'h0, "x0_same_p0");
    exp_next(K_RD1, 32'h0, "x0_same_p1");
    tick();
    set_wr(1'b0, 0, 32'h0);
    exp_next(K_RD0, 32'h0, "x0_next_p0");
    exp_next(K_RD1, 32'h0, "x0_next_p1");
    tick();

    // Stall: held addresses 9 / 5 track writes; new addresses are ignored.
    set_rd(1'b1, 9, 5);
    exp_next(K_RD0, 32'h0, "stall_pre_x9");
    exp_next(K_RD1, 32'hDEAD_BEEF, "stall_pre_x5");
    tick();
    set_rd(1'b0, 1, 2);
    set_wr(1'b1, 9, 32'h55);
    exp_next(K_RD0, 32'h55, "stall_w55");
    exp_next(K_RD1, 32'hDEAD_BEEF, "stall_hold_p1");
    tick();
    set_wr(1'b1, 9, 32'h66);
    exp_next(K_RD0, 32'h66, "stall_w66");
    tick();
    set_wr(1'b0, 0, 32'h0);
    exp_next(K_RD0, 32'h66, "stall_keep");
    exp_next(K_RD1, 32'hDEAD_BEEF, "stall_keep_p1");
    tick();

    // Clear request, then again with reset pulsed mid-clear.
    clear_scenario(1'b0);
    clear_scenario(1'b1);

    tick();
    tick();
    check(ready === 1'b1, "end_ready", {31'd0, ready}, 32'd1);
    check(rd_data[0*DW +: DW] === 32'h0, "end_rd0", rd_data[0*DW +: DW], 32'h0);
    check(rd_data[1*DW +: DW] === 32'h0, "end_rd1", rd_data[1*DW +: DW], 32'h0);
    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL unchecked_%s cyc=%0d actual=none required=%h", sb[0].name, sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_mp
